// File: rtl/sonar_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sonar_scan_ctrl_pkg
// Description : State codes and default timing for the sonar sweep sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sonar_scan_ctrl_pkg;

    localparam int c_STATE_W            = 4;
    localparam int c_SETTLE_CYCLES_DEF  = 50_000_000;
    localparam int c_TIMEOUT_CYCLES_DEF = 2_500_000;
    localparam int c_N_POS_DEF          = 8;
    localparam int c_POS_W_DEF          = 3;

    // Codes are shared with the debug 7-segment decode, so values are fixed.
    typedef enum logic [c_STATE_W-1:0] {
        ST_INICIAL       = 4'd0,
        ST_PREPARA       = 4'd1,
        ST_AGUARDA       = 4'd2,
        ST_MEDE          = 4'd3,
        ST_ESPERA_MEDIDA = 4'd4,
        ST_TRANSMITE     = 4'd5,
        ST_ESPERA_TX     = 4'd6,
        ST_PROXIMA       = 4'd7
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sonar_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sonar_scan_ctrl_if
// Description : Control/handshake bundle between top level and sweep sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sonar_scan_ctrl_if
    import sonar_scan_ctrl_pkg::*;
#(
    parameter int POS_W = c_POS_W_DEF
);
    logic                 ligar;
    logic                 meas_pronto;
    logic                 tx_pronto;
    logic [POS_W-1:0]     posicao;
    logic                 inicio_medir;
    logic                 inicio_tx;
    logic                 erro_medida;
    logic                 fim_posicao;
    logic [c_STATE_W-1:0] db_estado;

    modport master (
        output ligar, meas_pronto, tx_pronto,
        input  posicao, inicio_medir, inicio_tx, erro_medida, fim_posicao, db_estado
    );

    modport slave (
        input  ligar, meas_pronto, tx_pronto,
        output posicao, inicio_medir, inicio_tx, erro_medida, fim_posicao, db_estado
    );
endinterface
`default_nettype wire

// File: rtl/sonar_scan_ctrl_contador_m.sv
`default_nettype none
// ============================================================================
// Module      : contador_m
// Description : Generic mod-M counter with synchronous clear, enable and fim.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_m #(
    parameter int M = 8,
    parameter int W = 3
) (
    input  wire logic         clock,
    input  wire logic         reset,
    input  wire logic         i_clr,
    input  wire logic         i_en,
    output logic [W-1:0]      o_count,
    output logic              o_fim
);
    localparam logic [W-1:0] c_LAST = W'(M - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_fim   = (r_count == c_LAST);
endmodule
`default_nettype wire

// File: rtl/sonar_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sonar_scan_ctrl
// Description : Ping-pong servo sweep sequencer: settle, measure (with timeout),
//               report, advance.
// Revision    : 1.0 - initial release
// ============================================================================
module sonar_scan_ctrl
    import sonar_scan_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES  = c_SETTLE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF,
    parameter int N_POS          = c_N_POS_DEF,
    parameter int POS_W          = c_POS_W_DEF
) (
    input  wire logic         clock,
    input  wire logic         reset,
    sonar_scan_ctrl_if.slave  bus
);
    localparam int c_TIMER_M = max_int(SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam int c_TIMER_W = cnt_width(c_TIMER_M);

    localparam logic [c_TIMER_W-1:0] c_SETTLE_LAST  = c_TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [POS_W-1:0]     c_POS_BEFORE_TOP = POS_W'(N_POS - 2);
    localparam logic [POS_W-1:0]     c_POS_ONE        = POS_W'(1);

    state_t                r_state;
    logic [POS_W-1:0]      r_posicao;
    logic                  r_dir_up;
    logic                  r_inicio_medir;
    logic                  r_inicio_tx;
    logic                  r_erro_medida;
    logic                  r_fim_posicao;

    logic [c_TIMER_W-1:0]  w_count;
    logic                  w_timer_fim;
    logic                  w_timer_clr;
    logic                  w_timer_en;
    logic                  w_settle_done;
    logic                  w_timeout;

    contador_m #(
        .M (c_TIMER_M),
        .W (c_TIMER_W)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (w_timer_clr),
        .i_en    (w_timer_en),
        .o_count (w_count),
        .o_fim   (w_timer_fim)
    );

    // The longer of the two limits coincides with the counter's own terminal count.
    assign w_settle_done = (SETTLE_CYCLES  == c_TIMER_M) ? w_timer_fim : (w_count == c_SETTLE_LAST);
    assign w_timeout     = (TIMEOUT_CYCLES == c_TIMER_M) ? w_timer_fim : (w_count == c_TIMEOUT_LAST);

    // Timer is zero on entry to AGUARDA and MEDE; the timeout window opens in
    // the inicio_medir cycle itself, so MEDE counts as its first cycle.
    always_comb begin
        w_timer_clr = 1'b0;
        w_timer_en  = 1'b0;
        case (r_state)
            ST_AGUARDA: begin
                w_timer_en  = 1'b1;
                w_timer_clr = w_settle_done;
            end
            ST_MEDE, ST_ESPERA_MEDIDA: begin
                w_timer_en  = 1'b1;
            end
            default: begin
                w_timer_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_INICIAL;
            r_posicao      <= '0;
            r_dir_up       <= 1'b1;
            r_inicio_medir <= 1'b0;
            r_inicio_tx    <= 1'b0;
            r_erro_medida  <= 1'b0;
            r_fim_posicao  <= 1'b0;
        end else begin
            r_inicio_medir <= 1'b0;
            r_inicio_tx    <= 1'b0;
            r_fim_posicao  <= 1'b0;
            case (r_state)
                ST_INICIAL: begin
                    if (bus.ligar) r_state <= ST_PREPARA;
                end
                ST_PREPARA: begin
                    r_posicao <= '0;
                    r_dir_up  <= 1'b1;
                    r_state   <= bus.ligar ? ST_AGUARDA : ST_INICIAL;
                end
                ST_AGUARDA: begin
                    if (!bus.ligar) begin
                        r_state <= ST_INICIAL;
                    end else if (w_settle_done) begin
                        r_state        <= ST_MEDE;
                        r_inicio_medir <= 1'b1;
                        r_erro_medida  <= 1'b0;
                    end
                end
                ST_MEDE: begin
                    r_state <= bus.ligar ? ST_ESPERA_MEDIDA : ST_INICIAL;
                end
                ST_ESPERA_MEDIDA: begin
                    if (!bus.ligar) begin
                        r_state <= ST_INICIAL;
                    end else if (bus.meas_pronto) begin
                        r_state     <= ST_TRANSMITE;
                        r_inicio_tx <= 1'b1;
                    end else if (w_timeout) begin
                        r_state       <= ST_TRANSMITE;
                        r_inicio_tx   <= 1'b1;
                        r_erro_medida <= 1'b1;
                    end
                end
                ST_TRANSMITE: begin
                    r_state <= bus.ligar ? ST_ESPERA_TX : ST_INICIAL;
                end
                ST_ESPERA_TX: begin
                    // A started frame always completes; ligar only decides where we go after.
                    if (bus.tx_pronto) begin
                        if (bus.ligar) begin
                            r_state       <= ST_PROXIMA;
                            r_fim_posicao <= 1'b1;
                            if (r_dir_up) begin
                                r_posicao <= r_posicao + c_POS_ONE;
                                if (r_posicao == c_POS_BEFORE_TOP) r_dir_up <= 1'b0;
                            end else begin
                                r_posicao <= r_posicao - c_POS_ONE;
                                if (r_posicao == c_POS_ONE) r_dir_up <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_INICIAL;
                        end
                    end
                end
                ST_PROXIMA: begin
                    r_state <= bus.ligar ? ST_AGUARDA : ST_INICIAL;
                end
                default: begin
                    r_state <= ST_INICIAL;
                end
            endcase
        end
    end

    assign bus.posicao      = r_posicao;
    assign bus.inicio_medir = r_inicio_medir;
    assign bus.inicio_tx    = r_inicio_tx;
    assign bus.erro_medida  = r_erro_medida;
    assign bus.fim_posicao  = r_fim_posicao;
    assign bus.db_estado    = r_state;
endmodule
`default_nettype wire
